// File: rtl/acc_mul_feed.sv
// acc_mul_feed: 4-lane signed multiply feed stage for the accumulator/output stage.
// Accepts activation/weight beats over valid/ready, registers one product per lane,
// and sequences the accumulator clear/add/stop/total controls for each job.
// Optional build macro: ACC_FEED_PERF_EN adds the perf_stall RUN-stall counter output.
module acc_mul_feed #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      job_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DATA_W-1:0]   a_vec,
   input  logic [4*DATA_W-1:0]   w_vec,
   output logic [31:0]           data0,
   output logic [31:0]           data1,
   output logic [31:0]           data2,
   output logic [31:0]           data3,
   output logic                  data_valid,
   output logic [2:0]            sig,
   output logic [3:0]            clear_reg,
   output logic                  clear_total,
   output logic [3:0]            is_stop,
   output logic                  is_stop_total,
   output logic                  busy,
   output logic                  done
`ifdef ACC_FEED_PERF_EN
   ,
   output logic [15:0]           perf_stall
`endif
);

   localparam int unsigned LANES  = 4;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned OUT_W  = 32;
   localparam int unsigned PERF_W = 16;

   localparam logic [2:0] SIG_IDLE  = 3'b000;
   localparam logic [2:0] SIG_ADD   = 3'b001;
   localparam logic [2:0] SIG_TOTAL = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_STOP_CH = 3'd4,
      S_TOTAL   = 3'd5,
      S_STOP_T  = 3'd6
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;

   logic start_ok_c;
   logic accept_c;
   logic last_beat_c;

   // next-cycle values of the state-decoded controls
   logic        in_ready_d;
   logic [2:0]  sig_d;
   logic [3:0]  clear_reg_d;
   logic        clear_total_d;
   logic [3:0]  is_stop_d;
   logic        is_stop_total_d;
   logic        busy_d;
   logic        done_d;

   logic signed [PROD_W-1:0] prod_c [LANES];
   logic        [OUT_W-1:0]  data_q [LANES];

   // handshake qualifiers; in_ready is itself the registered decode of RUN
   assign start_ok_c  = (state_q == S_IDLE) && start && (job_len != '0);
   assign accept_c    = (state_q == S_RUN) && in_valid && in_ready;
   assign last_beat_c = (cnt_q == (len_q - LEN_W'(1)));

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok_c) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR:   state_d = S_RUN;
         S_RUN: begin
            if (accept_c && last_beat_c) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN:   state_d = S_STOP_CH;
         S_STOP_CH: state_d = S_TOTAL;
         S_TOTAL:   state_d = S_STOP_T;
         S_STOP_T:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // output decode of the upcoming state, so the registered controls track state_q
   always_comb begin
      in_ready_d      = 1'b0;
      sig_d           = SIG_IDLE;
      clear_reg_d     = 4'h0;
      clear_total_d   = 1'b0;
      is_stop_d       = 4'h0;
      is_stop_total_d = 1'b0;
      busy_d          = (state_d != S_IDLE);
      done_d          = 1'b0;
      case (state_d)
         S_CLEAR: begin
            clear_reg_d   = 4'hF;
            clear_total_d = 1'b1;
         end
         S_RUN: begin
            in_ready_d = 1'b1;
            sig_d      = SIG_ADD;
         end
         S_DRAIN: begin
            sig_d = SIG_ADD;
         end
         S_STOP_CH: begin
            sig_d     = SIG_ADD;
            is_stop_d = 4'hF;
         end
         S_TOTAL: begin
            sig_d = SIG_TOTAL;
         end
         S_STOP_T: begin
            is_stop_total_d = 1'b1;
            done_d          = 1'b1;
         end
         default: begin
            sig_d = SIG_IDLE;
         end
      endcase
   end

   // control output register
   always_ff @(posedge clk) begin
      if (!rst) begin
         in_ready      <= 1'b0;
         sig           <= SIG_IDLE;
         clear_reg     <= 4'h0;
         clear_total   <= 1'b0;
         is_stop       <= 4'h0;
         is_stop_total <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         in_ready      <= in_ready_d;
         sig           <= sig_d;
         clear_reg     <= clear_reg_d;
         clear_total   <= clear_total_d;
         is_stop       <= is_stop_d;
         is_stop_total <= is_stop_total_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

   // job length latch and accepted-beat counter (LEN_W wide, no early wrap)
   always_ff @(posedge clk) begin
      if (!rst) begin
         len_q <= '0;
         cnt_q <= '0;
      end else if (start_ok_c) begin
         len_q <= job_len;
         cnt_q <= '0;
      end else if (accept_c) begin
         cnt_q <= cnt_q + LEN_W'(1);
      end
   end

   // per-lane signed products, full precision
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0] a_s;
      logic signed [DATA_W-1:0] w_s;
      assign a_s       = a_vec[k*DATA_W +: DATA_W];
      assign w_s       = w_vec[k*DATA_W +: DATA_W];
      assign prod_c[k] = PROD_W'(a_s) * PROD_W'(w_s);
   end

   // product register: loads only on an accepted beat, otherwise holds
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_valid <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         data_valid <= accept_c;
         if (accept_c) begin
            for (int k = 0; k < LANES; k++) begin
               data_q[k] <= OUT_W'(prod_c[k]);
            end
         end
      end
   end

   assign data0 = data_q[0];
   assign data1 = data_q[1];
   assign data2 = data_q[2];
   assign data3 = data_q[3];

`ifdef ACC_FEED_PERF_EN
   // saturating count of RUN cycles without an offered beat
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall <= '0;
      end else if (start_ok_c) begin
         perf_stall <= '0;
      end else if ((state_q == S_RUN) && !in_valid && (perf_stall != {PERF_W{1'b1}})) begin
         perf_stall <= perf_stall + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_acc_mul_feed.sv
// Directed bench for acc_mul_feed: table-driven product vectors plus hand sequences
// for stalls, zero-length start, restart while busy, mid-job reset and max job length.
module tb_acc_mul_feed;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [LEN_W-1:0]    job_len;
   logic                in_valid;
   logic                in_ready;
   logic [4*DATA_W-1:0] a_vec;
   logic [4*DATA_W-1:0] w_vec;
   logic [31:0]         data0, data1, data2, data3;
   logic                data_valid;
   logic [2:0]          sig;
   logic [3:0]          clear_reg;
   logic                clear_total;
   logic [3:0]          is_stop;
   logic                is_stop_total;
   logic                busy;
   logic                done;
`ifdef ACC_FEED_PERF_EN
   logic [15:0]         perf_stall;
`endif

   acc_mul_feed #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .job_len(job_len),
      .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .w_vec(w_vec),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .data_valid(data_valid), .sig(sig), .clear_reg(clear_reg),
      .clear_total(clear_total), .is_stop(is_stop), .is_stop_total(is_stop_total),
      .busy(busy), .done(done)
`ifdef ACC_FEED_PERF_EN
      , .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] w;
      logic [31:0] e0, e1, e2, e3;
   } vec_t;

   vec_t vecs [5];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [63:0] pack4(int l0, int l1, int l2, int l3);
      return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " clr"}, 32'({clear_reg, clear_total}), 32'd0);
      chk({tag, " stop"}, 32'({is_stop, is_stop_total}), 32'd0);
      chk({tag, " sig/rdy"}, 32'({sig, in_ready}), 32'd0);
   endtask

   // full job with in_valid held high; optional start pulse while running
   task automatic run_job(input int first, input int n, input bit restart);
      start = 1'b1; job_len = LEN_W'(n);
      step();
      start = 1'b0;
      chk("clear strobes", 32'({clear_reg, clear_total}), 32'h1F);
      chk("clear sig/rdy", 32'({sig, in_ready, busy}), 32'b0001);
      a_vec = vecs[first].a; w_vec = vecs[first].w; in_valid = 1'b1;
      step();
      chk("run entry", 32'({sig, in_ready}), 32'b0011);
      for (int i = 0; i < n; i++) begin
         a_vec = vecs[first+i].a; w_vec = vecs[first+i].w;
         if (restart && i == 1) begin
            start = 1'b1; job_len = LEN_W'(2);
         end
         step();
         start = 1'b0;
         chk("beat valid", 32'(data_valid), 32'd1);
         chk("data0", data0, vecs[first+i].e0);
         chk("data1", data1, vecs[first+i].e1);
         chk("data2", data2, vecs[first+i].e2);
         chk("data3", data3, vecs[first+i].e3);
         chk("ready after beat", 32'(in_ready), (i < n-1) ? 32'd1 : 32'd0);
         chk("done early", 32'(done), 32'd0);
      end
      in_valid = 1'b0;
      chk("drain sig", 32'(sig), 32'b001);
      step();
      chk("stop_ch", 32'({is_stop, sig, data_valid, done}), {23'd0, 4'hF, 3'b001, 2'b00});
      step();
      chk("total sig", 32'({sig, is_stop, done}), {24'd0, 3'b010, 4'h0, 1'b0});
      step();
      chk("stop_t", 32'({is_stop_total, sig, done, busy}), {26'd0, 1'b1, 3'b000, 1'b1, 1'b1});
      step();
      chk("back idle", 32'({busy, done, is_stop_total}), 32'd0);
   endtask

   int dv_pulses;
   int errs;

   initial begin
      vecs[0] = '{pack4(2, 1, -1, 100), pack4(3, -1, -1, 200),
                  32'd6, 32'hFFFF_FFFF, 32'd1, 32'd20000};
      vecs[1] = '{pack4(-4, 0, 32767, -100), pack4(5, 1234, 32767, 3),
                  32'hFFFF_FFEC, 32'd0, 32'h3FFF_0001, 32'hFFFF_FED4};
      vecs[2] = '{pack4(7, -32768, 10, 5), pack4(-1, 32767, 10, -5),
                  32'hFFFF_FFF9, 32'hC000_8000, 32'h64, 32'hFFFF_FFE7};
      vecs[3] = '{pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768),
                  32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      vecs[4] = '{pack4(-32768, 3, -2, 0), pack4(-32768, -3, -2, -32768),
                  32'h4000_0000, 32'hFFFF_FFF7, 32'd4, 32'd0};

      rst = 1'b0; start = 1'b0; job_len = '0; in_valid = 1'b0; a_vec = '0; w_vec = '0;
      step(); step();
      chk_idle_outputs("reset");
      chk("reset data", data0 | data1 | data2 | data3, 32'd0);
      chk("reset dv", 32'(data_valid), 32'd0);
      rst = 1'b1;
      step();

      // basic 3-beat job
      run_job(0, 3, 1'b0);

      // most-negative products and lane independence
      run_job(3, 2, 1'b0);

      // zero-length start is ignored
      start = 1'b1; job_len = '0;
      step();
      start = 1'b0;
      chk_idle_outputs("len0 a");
      step();
      chk_idle_outputs("len0 b");

      // start while busy is ignored
      run_job(0, 4, 1'b1);
      step();
      chk("no queued start", 32'(busy), 32'd0);

      // stall of 5 cycles between two beats
      dv_pulses = 0;
      start = 1'b1; job_len = LEN_W'(2);
      step();
      start = 1'b0;
      a_vec = vecs[1].a; w_vec = vecs[1].w; in_valid = 1'b1;
      step();
      step();
      if (data_valid) dv_pulses++;
      chk("stall beat0", data0, vecs[1].e0);
      in_valid = 1'b0; a_vec = vecs[2].a; w_vec = vecs[2].w;
      for (int i = 0; i < 5; i++) begin
         step();
         if (data_valid) dv_pulses++;
         chk("stall ready", 32'(in_ready), 32'd1);
         chk("stall hold", data2, vecs[1].e2);
      end
      in_valid = 1'b1;
      step();
      if (data_valid) dv_pulses++;
      chk("stall beat1", data1, vecs[2].e1);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (data_valid) dv_pulses++;
      end
      chk("stall dv pulses", 32'(dv_pulses), 32'd2);
      chk("stall idle", 32'(busy), 32'd0);
`ifdef ACC_FEED_PERF_EN
      chk("perf_stall", 32'(perf_stall), 32'd5);
      step();
      chk("perf hold", 32'(perf_stall), 32'd5);
`endif

      // reset mid-job abandons it silently
      start = 1'b1; job_len = LEN_W'(3);
      step();
      start = 1'b0;
      a_vec = vecs[0].a; w_vec = vecs[0].w; in_valid = 1'b1;
      step();
      step();
      chk("pre-reset beat", data0, vecs[0].e0);
      rst = 1'b0;
      step();
      chk_idle_outputs("midrst");
      chk("midrst data", data0 | data1 | data2 | data3, 32'd0);
      chk("midrst dv", 32'(data_valid), 32'd0);
      rst = 1'b1;
      errs = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (busy || done || in_ready || data_valid) errs++;
      end
      chk("midrst quiet", 32'(errs), 32'd0);
      in_valid = 1'b0;
      run_job(0, 3, 1'b0);

      // maximum job length must not terminate early
      start = 1'b1; job_len = LEN_W'(255);
      step();
      start = 1'b0;
      a_vec = pack4(1, 2, 3, 4); w_vec = pack4(1, 1, 1, 1); in_valid = 1'b1;
      step();
      errs = 0;
      for (int i = 0; i < 255; i++) begin
         step();
         if (!data_valid) errs++;
         if (i < 254 && !in_ready) errs++;
      end
      in_valid = 1'b0;
      chk("maxlen beats", 32'(errs), 32'd0);
      chk("maxlen ready off", 32'(in_ready), 32'd0);
      chk("maxlen data3", data3, 32'd4);
      step(); step();
      chk("maxlen not done", 32'(done), 32'd0);
      step();
      chk("maxlen done", 32'(done), 32'd1);
      step();
      chk("maxlen idle", 32'({busy, done}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
